// File: rtl/branch_predictor_2lvl.sv
// Two-level adaptive branch predictor: local (per-hash BHR) or gshare indexing,
// combinational prediction, edge-trained saturating PHT and saturating accuracy stats.
module branch_predictor_2lvl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int HASH_WIDTH     = 4,
    parameter int HISTORY_LENGTH = 4,
    parameter int CNT_WIDTH      = 2,
    parameter int MODE           = 0,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  IFPD_predict_en,
    input  logic [ADDR_WIDTH-1:0] IFPD_pc,
    input  logic                  IFPD_feedback_en,
    input  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
    input  logic                  IFPD_branch_result,
    input  logic                  IFPD_feedback_predicted,
    output logic                  PDIF_predict_result,
    output logic [STAT_WIDTH-1:0] PDIF_total_cnt,
    output logic [STAT_WIDTH-1:0] PDIF_miss_cnt
);
    localparam int IDX_WIDTH = (MODE == 1) ? HASH_WIDTH : HASH_WIDTH + HISTORY_LENGTH;
    localparam int PHT_DEPTH = 1 << IDX_WIDTH;
    localparam int NUM_BHR   = (MODE == 1) ? 1 : (1 << HASH_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    logic [CNT_WIDTH-1:0]      pht [PHT_DEPTH];
    logic [HISTORY_LENGTH-1:0] bhr [NUM_BHR];

    logic [HASH_WIDTH-1:0]     pred_hash, fb_hash;
    logic [IDX_WIDTH-1:0]      pred_idx, fb_idx;
    logic [HISTORY_LENGTH-1:0] fb_hist, fb_hist_next;
    logic [CNT_WIDTH-1:0]      fb_cnt, fb_cnt_next;
    logic                      upd;

    assign pred_hash = IFPD_pc[HASH_WIDTH+1:2];
    assign fb_hash   = IFPD_feedback_pc[HASH_WIDTH+1:2];
    assign upd       = IFPD_feedback_en && Sys_rdy;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IFPD_pc[ADDR_WIDTH-1:HASH_WIDTH+2], IFPD_pc[1:0],
                              IFPD_feedback_pc[ADDR_WIDTH-1:HASH_WIDTH+2], IFPD_feedback_pc[1:0]};

    generate
        if (MODE == 1) begin : g_gshare
            assign fb_hist  = bhr[0];
            assign pred_idx = pred_hash ^ IDX_WIDTH'(bhr[0]);
            assign fb_idx   = fb_hash ^ IDX_WIDTH'(fb_hist);
        end else begin : g_local
            assign fb_hist  = bhr[fb_hash];
            assign pred_idx = {pred_hash, bhr[pred_hash]};
            assign fb_idx   = {fb_hash, fb_hist};
        end

        // Newest outcome enters at the LSB, oldest falls off the top.
        if (HISTORY_LENGTH == 1) begin : g_hist1
            assign fb_hist_next = IFPD_branch_result;
        end else begin : g_histn
            assign fb_hist_next = {fb_hist[HISTORY_LENGTH-2:0], IFPD_branch_result};
        end
    endgenerate

    assign PDIF_predict_result = IFPD_predict_en & pht[pred_idx][CNT_WIDTH-1];

    assign fb_cnt = pht[fb_idx];
    always_comb begin
        fb_cnt_next = fb_cnt;
        if (IFPD_branch_result) begin
            if (fb_cnt != '1) fb_cnt_next = fb_cnt + 1'b1;
        end else begin
            if (fb_cnt != '0) fb_cnt_next = fb_cnt - 1'b1;
        end
    end

    // Decoded per-entry writes keep the tables as plain flops.
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CNT_INIT;
            for (int i = 0; i < NUM_BHR; i++)   bhr[i] <= '0;
        end else if (upd) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                if (IDX_WIDTH'(i) == fb_idx) pht[i] <= fb_cnt_next;
            for (int i = 0; i < NUM_BHR; i++)
                if (MODE == 1 || HASH_WIDTH'(i) == fb_hash) bhr[i] <= fb_hist_next;
        end
    end

    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            PDIF_total_cnt <= '0;
            PDIF_miss_cnt  <= '0;
        end else if (upd) begin
            if (PDIF_total_cnt != '1) PDIF_total_cnt <= PDIF_total_cnt + 1'b1;
            if ((IFPD_feedback_predicted != IFPD_branch_result) && (PDIF_miss_cnt != '1))
                PDIF_miss_cnt <= PDIF_miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Directed bench: default local-history predictor plus a gshare instance
// with 2-bit history and 4-bit saturating statistics.
module tb_branch_predictor_2lvl;
    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        rdy = 1'b1;
    logic        pred_en = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        fb_en0 = 1'b0, fb_en1 = 1'b0;
    logic [31:0] fb_pc = '0;
    logic        fb_res = 1'b0, fb_pred = 1'b0;
    logic        p0, p1;
    logic [31:0] tot0, miss0;
    logic [3:0]  tot1, miss1;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_2lvl dut0 (
        .Sys_clk(clk), .Sys_rst(rst0), .Sys_rdy(rdy),
        .IFPD_predict_en(pred_en), .IFPD_pc(pred_pc),
        .IFPD_feedback_en(fb_en0), .IFPD_feedback_pc(fb_pc),
        .IFPD_branch_result(fb_res), .IFPD_feedback_predicted(fb_pred),
        .PDIF_predict_result(p0), .PDIF_total_cnt(tot0), .PDIF_miss_cnt(miss0)
    );

    branch_predictor_2lvl #(.HISTORY_LENGTH(2), .MODE(1), .STAT_WIDTH(4)) dut1 (
        .Sys_clk(clk), .Sys_rst(rst1), .Sys_rdy(rdy),
        .IFPD_predict_en(pred_en), .IFPD_pc(pred_pc),
        .IFPD_feedback_en(fb_en1), .IFPD_feedback_pc(fb_pc),
        .IFPD_branch_result(fb_res), .IFPD_feedback_predicted(fb_pred),
        .PDIF_predict_result(p1), .PDIF_total_cnt(tot1), .PDIF_miss_cnt(miss1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fb0(input logic [31:0] pc, input logic res, input logic prd);
        fb_pc = pc; fb_res = res; fb_pred = prd; fb_en0 = 1'b1;
        @(posedge clk); #1;
        fb_en0 = 1'b0;
    endtask

    task automatic fb1(input logic [31:0] pc, input logic res, input logic prd);
        fb_pc = pc; fb_res = res; fb_pred = prd; fb_en1 = 1'b1;
        @(posedge clk); #1;
        fb_en1 = 1'b0;
    endtask

    task automatic pr(input logic [31:0] pc);
        pred_en = 1'b1; pred_pc = pc; #1;
    endtask

    task automatic reset0();
        rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1; rst0 = 1'b0; rst1 = 1'b0;

        // Reset state
        pr(32'h1000);        chk("rst_pred", 32'(p0), 0);
        chk("rst_total", tot0, 0);
        chk("rst_miss", miss0, 0);
        fb0(32'h1000, 1'b1, 1'b0);
        chk("fb1_total", tot0, 1);
        chk("fb1_miss", miss0, 1);
        pr(32'h1000);        chk("fb1_newhist_pred", 32'(p0), 0);

        // Local history fill and PHT saturation on hash 1
        reset0();
        for (int i = 0; i < 4; i++) fb0(32'h1004, 1'b1, 1'b0);
        chk("t4_total", tot0, 4);
        chk("t4_miss", miss0, 4);
        pr(32'h1004);        chk("t4_pred_bhr1111", 32'(p0), 0);
        fb0(32'h1004, 1'b1, 1'b0);
        pr(32'h1004);        chk("t5_pred", 32'(p0), 1);
        for (int i = 0; i < 3; i++) fb0(32'h1004, 1'b1, 1'b0);
        pr(32'h1004);        chk("t8_pred_sat", 32'(p0), 1);
        chk("t8_total", tot0, 8);
        pred_en = 1'b0; #1;  chk("pred_en_low", 32'(p0), 0);

        // Alternating pattern on hash 2
        reset0();
        for (int i = 0; i < 32; i++) begin
            fb0(32'h2008, (i % 2) == 0, 1'b0);
            pr(32'h2008);
            if (i >= 4) chk("alt_pred", 32'(p0), 32'(((i + 1) % 2) == 0));
        end
        chk("alt_total", tot0, 32);
        chk("alt_miss", miss0, 16);
        pr(32'h200C);        chk("alt_other_hash", 32'(p0), 0);

        // Same-cycle predict and feedback on the same entry
        reset0();
        for (int i = 0; i < 4; i++) fb0(32'h3010, 1'b1, 1'b0);
        pr(32'h3010);        chk("sc_before", 32'(p0), 0);
        fb_pc = 32'h3010; fb_res = 1'b1; fb_pred = 1'b0; fb_en0 = 1'b1;
        #1;                  chk("sc_same_cycle", 32'(p0), 0);
        @(posedge clk); #1;
        fb_en0 = 1'b0;       chk("sc_next_cycle", 32'(p0), 1);

        // Sys_rdy low freezes everything
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) fb0(32'h3010, 1'b0, 1'b1);
        chk("rdy0_total", tot0, 5);
        chk("rdy0_miss", miss0, 5);
        pr(32'h3010);        chk("rdy0_pred", 32'(p0), 1);
        rdy = 1'b1;
        fb0(32'h3010, 1'b0, 1'b1);
        chk("rdy1_total", tot0, 6);
        chk("rdy1_miss", miss0, 6);
        pr(32'h3010);        chk("rdy1_pred", 32'(p0), 0);
        fb0(32'h3010, 1'b0, 1'b0);
        chk("hit_total", tot0, 7);
        chk("hit_miss", miss0, 6);

        // gshare instance: XOR indexing and statistics saturation
        fb1(32'h0, 1'b1, 1'b0);
        fb1(32'h4, 1'b1, 1'b0);
        pr(32'hC);           chk("gs_xor_pred", 32'(p1), 1);
        for (int i = 0; i < 13; i++) fb1(32'hC, 1'b1, 1'b0);
        chk("gs_total15", 32'(tot1), 15);
        fb1(32'hC, 1'b1, 1'b0);
        chk("gs_total_sat", 32'(tot1), 15);
        chk("gs_miss_sat", 32'(miss1), 15);
        pr(32'hC);           chk("gs_pred_pre_rst", 32'(p1), 1);

        // Asynchronous reset between edges, held across a feedback edge
        fb_pc = 32'hC; fb_res = 1'b1; fb_pred = 1'b0; fb_en1 = 1'b1;
        #2; rst1 = 1'b1; #1;
        chk("arst_total", 32'(tot1), 0);
        chk("arst_miss", 32'(miss1), 0);
        pr(32'hC);           chk("arst_pred", 32'(p1), 0);
        @(posedge clk); #1;
        rst1 = 1'b0; fb_en1 = 1'b0; #1;
        chk("arst_fb_blocked", 32'(tot1), 0);
        fb1(32'hC, 1'b1, 1'b1);
        chk("gs_post_total", 32'(tot1), 1);
        chk("gs_post_miss", 32'(miss1), 0);
        pr(32'h8);           chk("gs_post_xor", 32'(p1), 1);
        pr(32'hC);           chk("gs_post_other", 32'(p1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
